mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter placed between the Qrisc32 core and the single `mem` instance. It lets instruction fetch and data load/store share the memory's one read port, and it forwards data-side writes to the memory's independent write port. It also returns read data to the port that issued the read, and prevents fetch starvation under sustained data reads. Memory access-fault pulses from `mem` are collected into a sticky, clearable fault status.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: number of consecutive denied fetch cycles after which fetch wins the read port. Legal range is 1..15.

Ports (name, direction, width, meaning):
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `reset`, in, 1: reset is synchronous and active-high.
- `ir_rd`, in, 1: fetch read request; held until `ir_ready`.
- `ir_addr`, in, 32: fetch byte address; held with `ir_rd`.
- `ir_ready`, out, 1: fetch read granted this cycle.
- `ir_valid`, out, 1: `ir_data` valid.
- `ir_data`, out, 32: fetched word.
- `dr_rd`, in, 1: data read request; held until `dr_ready`.
- `dr_wr`, in, 1: data write request.
- `dr_addr`, in, 32: data byte address, used for both reads and writes.
- `dr_wdata`, in, 32: write data.
- `dr_ready`, out, 1: data read granted this cycle.
- `dr_valid`, out, 1: `dr_rdata` valid.
- `dr_rdata`, out, 32: loaded word.
- `m_add_r`, out, 32: to memory read address.
- `m_add_w`, out, 32: to memory write address.
- `m_data_w`, out, 32: to memory write data.
- `m_rd`, out, 1: to memory read strobe.
- `m_wr`, out, 1: to memory write strobe.
- `m_data_r`, in, 32: from memory; registered read data, 1-cycle latency.
- `m_stop_active`, in, 1: from memory; fault pulse, registered, one cycle after the offending access.
- `fault_clr`, in, 1: clears fault status.
- `fault`, out, 1: sticky flag, set when any memory fault has occurred.
- `fault_cnt`, out, 8: saturating count of fault cycles.

## Operation
- **Writes:**
  - `dr_wr` is never stalled.
  - `m_wr = dr_wr & ~reset`, `m_add_w = dr_addr`, `m_data_w = dr_wdata`.
  - No write acknowledge is returned.
- **Read arbitration**, evaluated every cycle:
  - If only one of `ir_rd` / `dr_rd` is asserted, that port wins.
  - If both are asserted, data wins unless `starve_cnt == STARVE_LIMIT`, in which case fetch wins.
- **Grant outputs:**
  - The winner's ready is 1.
  - `m_rd = 1`.
  - `m_add_r` is the winner's address.
  - When there is no request: `m_rd = 0` and `m_add_r` holds `ir_addr`.
- **`starve_cnt`** (4 bits):
  - Increments when `ir_rd` is asserted and fetch is denied.
  - Cleared to 0 when fetch is granted or `ir_rd` is low.
  - Saturates at `STARVE_LIMIT`.
- **Return tracking:**
  - A registered owner field (NONE / IR / DR) records the current cycle's grant.
  - On the next cycle, the owner's valid is 1 and its data output equals `m_data_r`.
  - Both data outputs are driven from `m_data_r` at all times; only the valid flags qualify them.
- **Back-to-back reads:** one read per cycle is allowed, fully pipelined.
- **Same-cycle data read and write to the same word:** the read returns the old contents. A read issued one cycle after the write returns the new data.
- **Faults** (applied on each cycle edge):
  - `m_stop_active = 1` sets `fault = 1` and increments `fault_cnt`, which saturates at 255.
  - `fault_clr` alone clears `fault` and zeroes `fault_cnt`.
  - `fault_clr` together with `m_stop_active`: the new event wins, giving `fault = 1` and `fault_cnt = 1`.

## Timing
- **Reset values:**
  - `ir_valid`, `dr_valid`, `fault` = 0; `fault_cnt` = 0.
  - Owner = NONE; `starve_cnt` = 0.
- **During reset:** `ir_ready`, `dr_ready`, `m_rd` and `m_wr` are forced to 0.
- **Combinational paths:**
  - `ir_ready`, `dr_ready`, `m_rd` and `m_add_r` are combinational from the requests and `starve_cnt` (same-cycle grant).
  - The write path is combinational pass-through.
- **Read latency:** grant in cycle N gives valid in cycle N+1. Valid is a single-cycle pulse per grant.
- **Reset mid-operation:** a reset in cycle N+1 after a grant in cycle N suppresses that valid, and the read is dropped. Requesters must re-issue after reset.
- **Fault attribution:** a fault pulse arrives 1 cycle after the access that caused it. The arbiter only counts faults and does not attribute them to a port.

## Test plan
1. **Single fetch:** reset, preload `mem[3] = 0xDEADBEEF`, then `ir_rd = 1` with `ir_addr = 0x0C` for one cycle. Required: `ir_ready = 1` in the same cycle, then `ir_valid = 1` with `ir_data = 0xDEADBEEF` on the next cycle; `dr_valid` stays 0.
2. **Contention with starvation limit:** `STARVE_LIMIT = 4`, `ir_rd` and `dr_rd` held high continuously, `dr_ready` acknowledged each cycle. Required: data is granted for 4 cycles, fetch is granted in the 5th, then the pattern repeats.
3. **Write then read:** `dr_wr` to 0x10 with data 0x12345678 in cycle 0, `dr_rd` of 0x10 in cycle 1. Required: `dr_rdata = 0x12345678` in cycle 2. A same-cycle write and read of 0x10 returns the old value.
4. **Faults:** `ir_rd` to 0x101 (unaligned address). Required: `m_stop_active` one cycle later, then `fault = 1` and `fault_cnt = 1`. Three more faults give `fault_cnt = 4`. `fault_clr` then gives 0; `fault_clr` coinciding with a fault gives `fault_cnt = 1`.
5. **Reset mid-operation:** `dr_rd` granted in cycle N, `reset` asserted in cycle N+1. Required: `dr_valid = 0`, all outputs at their reset values, and `starve_cnt = 0` afterwards.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port arbiter between the Qrisc32 instruction-fetch port
//                and data load/store port, sharing the single read port of
//                the `mem` instance. Data writes pass straight through to the
//                memory's independent write port. Read data is returned to
//                the port that issued the read one cycle later. A bounded
//                starvation counter guarantees forward progress for fetch
//                under sustained data reads. Memory access-fault pulses are
//                gathered into a sticky, clearable flag and a saturating
//                8-bit counter.
//
//  Ports
//    clk, reset            : clock; synchronous active-high reset
//    ir_rd/ir_addr         : fetch read request and byte address
//    ir_ready              : fetch granted this cycle (combinational)
//    ir_valid/ir_data      : fetched word, one cycle after the grant
//    dr_rd/dr_wr/dr_addr   : data read/write request and byte address
//    dr_wdata              : data write value
//    dr_ready              : data read granted this cycle (combinational)
//    dr_valid/dr_rdata     : loaded word, one cycle after the grant
//    m_add_r/m_rd          : memory read address / read strobe
//    m_add_w/m_data_w/m_wr : memory write address / data / strobe
//    m_data_r              : memory read data (1-cycle registered)
//    m_stop_active         : memory fault pulse
//    fault_clr             : clear fault status
//    fault/fault_cnt       : sticky fault flag / saturating fault count
//
//  Revision    : 1.0  - initial release
// ============================================================================
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4   // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset,

    // Instruction-fetch port
    input  logic        ir_rd,
    input  logic [31:0] ir_addr,
    output logic        ir_ready,
    output logic        ir_valid,
    output logic [31:0] ir_data,

    // Data load/store port
    input  logic        dr_rd,
    input  logic        dr_wr,
    input  logic [31:0] dr_addr,
    input  logic [31:0] dr_wdata,
    output logic        dr_ready,
    output logic        dr_valid,
    output logic [31:0] dr_rdata,

    // Memory side
    output logic [31:0] m_add_r,
    output logic [31:0] m_add_w,
    output logic [31:0] m_data_w,
    output logic        m_rd,
    output logic        m_wr,
    input  logic [31:0] m_data_r,
    input  logic        m_stop_active,

    // Fault status
    input  logic        fault_clr,
    output logic        fault,
    output logic [7:0]  fault_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    // Owner of the read that is in flight in the memory pipeline
    localparam logic [1:0] c_OWN_NONE = 2'd0;
    localparam logic [1:0] c_OWN_IR   = 2'd1;
    localparam logic [1:0] c_OWN_DR   = 2'd2;

    localparam logic [7:0] c_FAULT_MAX = 8'hFF;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [3:0] r_starve_cnt;
    logic [1:0] r_owner;
    logic       r_fault;
    logic [7:0] r_fault_cnt;

    logic       w_fetch_priority;
    logic       w_grant_ir;
    logic       w_grant_dr;
    logic [1:0] w_owner_nxt;

    // ------------------------------------------------------------------------
    // Read arbitration (same-cycle grant)
    //   Data normally wins a contended cycle; once fetch has been denied
    //   STARVE_LIMIT consecutive cycles it takes the port for one cycle.
    //   All grants are suppressed while reset is asserted.
    // ------------------------------------------------------------------------
    always_comb begin
        w_fetch_priority = (r_starve_cnt == c_STARVE_LIMIT);
        w_grant_ir       = 1'b0;
        w_grant_dr       = 1'b0;
        if (!reset) begin
            if (ir_rd && dr_rd) begin
                w_grant_ir = w_fetch_priority;
                w_grant_dr = !w_fetch_priority;
            end else begin
                w_grant_ir = ir_rd;
                w_grant_dr = dr_rd;
            end
        end
    end

    always_comb begin
        w_owner_nxt = c_OWN_NONE;
        if (w_grant_ir) begin
            w_owner_nxt = c_OWN_IR;
        end else if (w_grant_dr) begin
            w_owner_nxt = c_OWN_DR;
        end
    end

    assign ir_ready = w_grant_ir;
    assign dr_ready = w_grant_dr;
    assign m_rd     = w_grant_ir | w_grant_dr;
    // With no data grant (including idle) the read address rests on ir_addr.
    assign m_add_r  = w_grant_dr ? dr_addr : ir_addr;

    // ------------------------------------------------------------------------
    // Write path: unconditional pass-through, never stalled
    // ------------------------------------------------------------------------
    assign m_wr     = dr_wr & ~reset;
    assign m_add_w  = dr_addr;
    assign m_data_w = dr_wdata;

    // ------------------------------------------------------------------------
    // Fetch starvation counter
    //   Counts consecutive cycles in which fetch requested but lost. Any
    //   cycle where fetch is granted or not requesting restarts the count.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= 4'd0;
        end else if (ir_rd && !w_grant_ir) begin
            if (r_starve_cnt != c_STARVE_LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else begin
            r_starve_cnt <= 4'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Return tracking
    //   The memory answers one cycle after the strobe, so the owner recorded
    //   at the grant edge qualifies m_data_r in the following cycle. Valids
    //   are also gated by reset so a reset landing in the return cycle drops
    //   the in-flight read.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= c_OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    assign ir_valid = (r_owner == c_OWN_IR) & ~reset;
    assign dr_valid = (r_owner == c_OWN_DR) & ~reset;
    assign ir_data  = m_data_r;
    assign dr_rdata = m_data_r;

    // ------------------------------------------------------------------------
    // Fault status
    //   A fault arriving in the same cycle as a clear is kept: the clear
    //   empties the history and the new event is counted as the first one.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault     <= 1'b0;
            r_fault_cnt <= 8'd0;
        end else if (m_stop_active) begin
            r_fault <= 1'b1;
            if (fault_clr) begin
                r_fault_cnt <= 8'd1;
            end else if (r_fault_cnt != c_FAULT_MAX) begin
                r_fault_cnt <= r_fault_cnt + 8'd1;
            end
        end else if (fault_clr) begin
            r_fault     <= 1'b0;
            r_fault_cnt <= 8'd0;
        end
    end

    assign fault     = r_fault;
    assign fault_cnt = r_fault_cnt;

endmodule
`default_nettype wire
